led_pwm_driver: RTL and testbench
=================================

# led_pwm_driver

Downstream consumer of the 10-bit LED PIO word in the accelerometer Nios subsystem. Takes the raw on/off LED pattern and drives the physical LEDs with global PWM brightness and an optional blink gate. A small Avalon-MM slave, with zero wait states and a combinational read, configures it. Sits between the LED PIO `out_port` and the top-level `LEDR` pins.

## Interface
- `PRESCALE`, 500: clk cycles per PWM tick; minimum 2.
- `NUM_LEDS`, 10: width of the LED pattern.
- `clk` in 1: system clock, 50 MHz.
- `reset_n` in 1: reset, asynchronous, active-low; clock `clk`.
- `led_in` in NUM_LEDS: pattern from the LED PIO.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read data.
- `led_out` out NUM_LEDS: registered LED drive.

## Operation
- Register map:
  - addr0 CTRL: bit0 `enable`, bit1 `blink_en`. Reset value 2'b01.
  - addr1 DUTY: bits[7:0] `duty_wr`. Reset value 255.
  - addr2 BLINK: bits[15:0] `blink_half`, counted in PWM periods. Reset value 0.
  - addr3 STATUS: read-only, returns `led_out`. Writes to addr3 are ignored.
- A write occurs when `chipselect && !write_n`. It updates the addressed register on that clock edge.
- Readback:
  - CTRL and BLINK return the stored value, zero-extended.
  - DUTY returns `duty_wr`, not the active shadow value.
- Timebase:
  - `presc` counts 0..PRESCALE-1. `tick` is asserted on the cycle `presc == PRESCALE-1`.
  - `pwm_cnt` counts 0..254 and advances on `tick`.
  - `wrap` is asserted on the `tick` where `pwm_cnt == 254`.
- Duty:
  - `duty_act` loads from `duty_wr` only on `wrap`. This keeps every PWM period glitch-free.
  - The PWM output `pwm_on` is `pwm_cnt < duty_act`.
  - Duty 0 means always off. Duty 255 means always on. This holds because `pwm_cnt` never reaches 255.
- Blink:
  - `blink_cnt` increments on `wrap`.
  - When `blink_cnt == blink_half-1`: `blink_cnt` goes to 0 and `blink_phase` toggles.
  - `blink_half == 0`: `blink_phase` is held at 1.
  - Any BLINK write clears `blink_cnt` and sets `blink_phase` to 1 on the same edge.
- Output:
  - `led_q <= led_in` every cycle.
  - `led_out <= (enable && pwm_on && (!blink_en || blink_phase)) ? led_q : 0`.
- `enable` = 0 forces `led_out` to 0 within 1 cycle. The counters keep running.

## Timing
- Reset values:
  - `led_out` = 0 and `led_q` = 0.
  - `presc`, `pwm_cnt` and `blink_cnt` = 0.
  - `blink_phase` = 1 and `duty_act` = 255.
  - `readdata` follows its combinational value from the reset register state.
- `led_in` to `led_out` latency is 2 clk cycles.
- PWM period is 255·PRESCALE clk. With defaults: 127 500 clk, about 392 Hz.
- A DUTY write takes effect on the first `led_out` update after the next `wrap`. With DUTY and CTRL, the new value is visible at readback the cycle after the write.
- Blink full period is 2·`blink_half` PWM periods.
- Write to BLINK on the same edge as a `wrap`: the write wins. Counter = 0, phase = 1.
- Reset asserted mid-period: all state returns to reset values immediately, with no clock needed.
- Reset release: counting starts on the first clk edge after deassertion.

## Structure
- Package `led_drv_pkg` holds:
  - Address constants `ADDR_CTRL`, `ADDR_DUTY`, `ADDR_BLINK`, `ADDR_STATUS`.
  - `PWM_MAX` = 254.
  - Reset constants `CTRL_RST` = 2'b01, `DUTY_RST` = 8'd255, `BLINK_RST` = 16'd0.
- Sub-module `led_pwm_timebase` contains:
  - The prescaler and `pwm_cnt`.
  - Outputs `pwm_cnt`, `tick` and `wrap`.
- The top level holds the register file, the duty shadow, blink logic and the output register.

## Test plan
All scenarios use PRESCALE=4 unless stated.
- **Reset and latency.** Hold reset, then release with `led_in` = 10'h2A5. Required:
  - `led_out` = 0 during reset.
  - `led_out` = 10'h2A5 from the 2nd edge after release.
  - readdata = 1, 255, 0 and 10'h2A5 for addr0..addr3.
- **Duty 128.** Write DUTY = 128 and wait for `wrap`. Required:
  - `led_out` = `led_in` for exactly 512 clk, then 0 for 508 clk.
  - This repeats every 1020 clk.
- **Duty extremes.**
  - DUTY = 0: `led_out` is constantly 0 across 3 periods.
  - DUTY = 255: `led_out` constantly equals `led_in`.
- **Blink.** Set CTRL = 3 and BLINK = 2. Required: `led_out` is active (PWM) for 2 PWM periods (2040 clk), then 0 for 2040 clk, repeating. A BLINK write mid-off-phase restores the on phase next cycle.
- **Mid-period duty change.** Write DUTY = 64 at `pwm_cnt` = 100 while the old duty is 200. Required: the current period still ends high-time at `pwm_cnt` = 200, and the next period uses 64.
- **Reset mid-operation.** Assert `reset_n` low asynchronously during the blink-off phase. Required:
  - `led_out` = 0 immediately.
  - After release, CTRL = 1 and `led_out` follows `led_in` 2 cycles later.

Source files
------------

// File: rtl/led_drv_pkg.sv
// Shared constants for the LED PWM driver: register map, PWM range and
// register reset values.
package led_drv_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [7:0] PWM_MAX = 8'd254;

  localparam logic [1:0]  CTRL_RST  = 2'b01;
  localparam logic [7:0]  DUTY_RST  = 8'd255;
  localparam logic [15:0] BLINK_RST = 16'd0;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: a clock prescaler producing tick, and an 8-bit PWM phase
// counter running 0..PWM_MAX that flags wrap on its last tick.
module led_pwm_timebase
  import led_drv_pkg::*;
#(
  parameter int unsigned PRESCALE = 500
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] pwm_cnt,
  output logic       tick,
  output logic       wrap
);

  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;

  assign tick    = (presc_q == PW'(PRESCALE - 1));
  assign wrap    = tick && (pwm_cnt_q == PWM_MAX);
  assign pwm_cnt = pwm_cnt_q;

  always_comb begin
    presc_d   = tick ? '0 : presc_q + PW'(1);
    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = wrap ? 8'd0 : pwm_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM driver: Avalon-MM configured global brightness and blink gate
// applied to the LED PIO pattern before it reaches the pins.
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned PRESCALE = 500,
  parameter int unsigned NUM_LEDS = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  logic [7:0] pwm_cnt;
  logic       tick;
  logic       wrap;

  led_pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk    (clk),
    .reset_n(reset_n),
    .pwm_cnt(pwm_cnt),
    .tick   (tick),
    .wrap   (wrap)
  );

  logic [1:0]          ctrl_q, ctrl_d;
  logic [7:0]          duty_wr_q, duty_wr_d;
  logic [7:0]          duty_act_q, duty_act_d;
  logic [15:0]         blink_half_q, blink_half_d;
  logic [15:0]         blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [NUM_LEDS-1:0] led_q;
  logic [NUM_LEDS-1:0] led_out_q, led_out_d;
  logic                wr_en;
  logic                pwm_on;
  logic                led_gate;

  assign wr_en    = chipselect && !write_n;
  assign pwm_on   = (pwm_cnt < duty_act_q);
  assign led_gate = ctrl_q[0] && pwm_on && (!ctrl_q[1] || blink_phase_q);
  assign led_out  = led_out_q;

  always_comb begin
    ctrl_d        = ctrl_q;
    duty_wr_d     = duty_wr_q;
    duty_act_d    = duty_act_q;
    blink_half_d  = blink_half_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    led_out_d     = led_gate ? led_q : '0;

    // Duty shadow only moves at a period boundary so no period is ever truncated.
    if (wrap) begin
      duty_act_d = duty_wr_q;
      if (blink_half_q == 16'd0) begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b1;
      end else if (blink_cnt_q == blink_half_q - 16'd1) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    // A BLINK write overrides a coincident wrap.
    if (wr_en) begin
      case (address)
        ADDR_CTRL: ctrl_d = writedata[1:0];
        ADDR_DUTY: duty_wr_d = writedata[7:0];
        ADDR_BLINK: begin
          blink_half_d  = writedata[15:0];
          blink_cnt_d   = '0;
          blink_phase_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[1:0]          = ctrl_q;
      ADDR_DUTY:   readdata[7:0]          = duty_wr_q;
      ADDR_BLINK:  readdata[15:0]         = blink_half_q;
      ADDR_STATUS: readdata[NUM_LEDS-1:0] = led_out_q;
      default:     readdata               = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q        <= CTRL_RST;
      duty_wr_q     <= DUTY_RST;
      duty_act_q    <= DUTY_RST;
      blink_half_q  <= BLINK_RST;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      led_q         <= '0;
      led_out_q     <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      duty_wr_q     <= duty_wr_d;
      duty_act_q    <= duty_act_d;
      blink_half_q  <= blink_half_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_q         <= led_in;
      led_out_q     <= led_out_d;
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: random LED patterns and register writes checked
// each cycle against a time-based arithmetic model of the PWM/blink rules.
module tb_led_pwm_driver;

  localparam int P   = 4;
  localparam int N   = 10;
  localparam int PER = 255 * P;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  led_in;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [N-1:0]  led_out;

  always #5 clk = ~clk;

  led_pwm_driver #(
    .PRESCALE(P),
    .NUM_LEDS(N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .led_in    (led_in),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .led_out   (led_out)
  );

  int vectors;
  int errors;

  // Model state: k counts clock edges since reset release.
  int           k;
  logic [1:0]   m_ctrl;
  int           m_duty_wr;
  int           m_duty_act;
  int           m_half;
  int           m_wraps;
  logic [N-1:0] m_led_q;
  logic [N-1:0] m_led_out;

  function automatic void model_reset();
    k          = 0;
    m_ctrl     = 2'b01;
    m_duty_wr  = 255;
    m_duty_act = 255;
    m_half     = 0;
    m_wraps    = 0;
    m_led_q    = '0;
    m_led_out  = '0;
  endfunction

  function automatic int m_pwm();
    return (k / P) % 255;
  endfunction

  // Phase = 1 during even-numbered groups of blink_half periods.
  function automatic bit m_phase();
    if (m_half == 0) return 1'b1;
    return ((m_wraps / m_half) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_rd(input int a);
    case (a)
      0:       return {30'd0, m_ctrl};
      1:       return 32'(m_duty_wr);
      2:       return 32'(m_half);
      default: return 32'(m_led_out);
    endcase
  endfunction

  // One clock edge: advance the model from the inputs present at the edge.
  task automatic cyc();
    logic [N-1:0] nxt;
    @(posedge clk);
    nxt = (m_ctrl[0] && (m_pwm() < m_duty_act) && (!m_ctrl[1] || m_phase())) ? m_led_q : '0;
    m_led_q = led_in;
    if ((k % PER) == PER - 1) begin
      m_duty_act = m_duty_wr;
      m_wraps++;
    end
    if (chipselect && !write_n) begin
      case (address)
        2'd0: m_ctrl = writedata[1:0];
        2'd1: m_duty_wr = int'(writedata[7:0]);
        2'd2: begin
          m_half  = int'(writedata[15:0]);
          m_wraps = 0;
        end
        default: ;
      endcase
    end
    m_led_out = nxt;
    k++;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    led_in = 10'h2A5;
    repeat (3) begin
      @(posedge clk);
      #1;
      vectors++;
      if (led_out !== '0) begin
        errors++;
        $display("FAIL reset_hold led_out=%h expected 0", led_out);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cyc();
    vectors++;
    if (led_out !== m_led_out) begin
      errors++;
      $display("FAIL reset_edge1 led_out=%h expected %h", led_out, m_led_out);
    end
    cyc();
    vectors++;
    if (led_out !== 10'h2A5) begin
      errors++;
      $display("FAIL reset_latency led_out=%h expected 2a5", led_out);
    end
    for (int a = 0; a < 4; a++) begin
      logic [31:0] exp;
      address = a[1:0];
      #1;
      exp = (a == 0) ? 32'd1 : (a == 1) ? 32'd255 : (a == 2) ? 32'd0 : 32'h2A5;
      vectors++;
      if (readdata !== exp) begin
        errors++;
        $display("FAIL reset_readback addr=%0d readdata=%h expected %h", a, readdata, exp);
      end
    end
  endtask

  task automatic test_duty_128();
    int stage = 0;
    int run   = 0;
    int exp;
    led_in = '1;
    wr(2'd1, 32'd128);
    for (int i = 0; i < 5000 && stage < 6; i++) begin
      cyc();
      vectors++;
      if (led_out !== m_led_out) begin
        errors++;
        $display("FAIL duty128 k=%0d led_out=%h expected %h", k, led_out, m_led_out);
      end
      if (stage == 0 && led_out == '0) stage = 1;
      else if (stage == 1 && led_out != '0) begin
        stage = 2;
        run   = 1;
      end else if (stage >= 2) begin
        if ((stage % 2 == 0) == (led_out != '0)) run++;
        else begin
          exp = (stage % 2 == 0) ? 512 : 508;
          vectors++;
          if (run != exp) begin
            errors++;
            $display("FAIL duty128_run stage=%0d length=%0d expected %0d", stage, run, exp);
          end
          stage++;
          run = 1;
        end
      end
    end
    vectors++;
    if (stage < 6) begin
      errors++;
      $display("FAIL duty128_timeout stage=%0d expected 6", stage);
    end
  endtask

  task automatic test_duty_extremes();
    logic [N-1:0] prev;
    wr(2'd1, 32'd0);
    for (int i = 0; i < 4 * PER; i++) begin
      led_in = N'($urandom);
      cyc();
      vectors++;
      if (led_out !== m_led_out) begin
        errors++;
        $display("FAIL duty0_model k=%0d led_out=%h expected %h", k, led_out, m_led_out);
      end
      if (i >= PER && led_out !== '0) begin
        errors++;
        $display("FAIL duty0 k=%0d led_out=%h expected 0", k, led_out);
      end
    end
    wr(2'd1, 32'd255);
    repeat (PER) cyc();
    prev = m_led_q;
    for (int i = 0; i < 2 * PER; i++) begin
      led_in = N'($urandom);
      cyc();
      vectors++;
      if (led_out !== prev) begin
        errors++;
        $display("FAIL duty255 k=%0d led_out=%h expected %h", k, led_out, prev);
      end
      prev = led_in;
    end
  endtask

  task automatic test_blink();
    int guard = 0;
    wr(2'd0, 32'd3);
    wr(2'd2, 32'd2);
    for (int i = 0; i < 8 * PER; i++) begin
      led_in = N'($urandom);
      cyc();
      vectors++;
      if (led_out !== m_led_out) begin
        errors++;
        $display("FAIL blink k=%0d led_out=%h expected %h", k, led_out, m_led_out);
      end
    end
    led_in = '1;
    while (m_phase() && guard < 3 * PER) begin
      cyc();
      guard++;
    end
    repeat (10) cyc();
    vectors++;
    if (led_out !== '0) begin
      errors++;
      $display("FAIL blink_off led_out=%h expected 0", led_out);
    end
    wr(2'd2, 32'd2);
    cyc();
    vectors++;
    if (led_out !== 10'h3FF) begin
      errors++;
      $display("FAIL blink_rewrite led_out=%h expected 3ff", led_out);
    end
  endtask

  task automatic test_mid_duty();
    int guard = 0;
    int run   = 0;
    int stage = 0;
    led_in = '1;
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd200);
    while (!(m_duty_act == 200 && m_pwm() == 100 && (k % P) == 0) && guard < 3 * PER) begin
      cyc();
      guard++;
    end
    wr(2'd1, 32'd64);
    for (int i = 0; i < 2 * PER && stage < 3; i++) begin
      cyc();
      vectors++;
      if (led_out !== m_led_out) begin
        errors++;
        $display("FAIL mid_duty k=%0d led_out=%h expected %h", k, led_out, m_led_out);
      end
      if (stage == 0) begin
        if (led_out != '0) run++;
        else begin
          vectors++;
          if (run != 399) begin
            errors++;
            $display("FAIL mid_duty_old high=%0d expected 399", run);
          end
          stage = 1;
        end
      end else if (stage == 1 && led_out != '0) begin
        stage = 2;
        run   = 1;
      end else if (stage == 2) begin
        if (led_out != '0) run++;
        else begin
          vectors++;
          if (run != 256) begin
            errors++;
            $display("FAIL mid_duty_new high=%0d expected 256", run);
          end
          stage = 3;
        end
      end
    end
    vectors++;
    if (stage < 3) begin
      errors++;
      $display("FAIL mid_duty_timeout stage=%0d expected 3", stage);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    logic [N-1:0] v;
    led_in = '1;
    wr(2'd1, 32'd255);
    wr(2'd0, 32'd3);
    wr(2'd2, 32'd1);
    while (m_phase() && guard < 3 * PER) begin
      cyc();
      guard++;
    end
    repeat (5) cyc();
    chipselect = 1'b0;
    address    = 2'd0;
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (led_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_async led_out=%h expected 0", led_out);
    end
    vectors++;
    if (readdata !== 32'd1) begin
      errors++;
      $display("FAIL reset_mid_ctrl readdata=%h expected 1", readdata);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (led_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_hold led_out=%h expected 0", led_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    v = N'($urandom);
    led_in = v;
    cyc();
    cyc();
    vectors++;
    if (led_out !== v) begin
      errors++;
      $display("FAIL reset_mid_latency led_out=%h expected %h", led_out, v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      led_in = N'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        logic [1:0]  a;
        logic [31:0] d;
        a = 2'($urandom);
        d = $urandom;
        if (a == 2'd2) d[15:0] = 16'($urandom_range(0, 3));
        wr(a, d);
      end else begin
        cyc();
      end
      vectors++;
      if (led_out !== m_led_out) begin
        errors++;
        $display("FAIL random k=%0d led_out=%h expected %h", k, led_out, m_led_out);
      end
      if (i % 250 == 0) begin
        for (int a = 0; a < 4; a++) begin
          address = a[1:0];
          #0.5;
          vectors++;
          if (readdata !== m_rd(a)) begin
            errors++;
            $display("FAIL random_readback addr=%0d readdata=%h expected %h",
                     a, readdata, m_rd(a));
          end
        end
      end
    end
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    led_in     = '0;
    model_reset();
    test_reset();
    test_duty_128();
    test_duty_extremes();
    test_blink();
    test_mid_duty();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
